// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;
  localparam int DEF_PC_STEP = 2;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential increment and PC-relative branch target.
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic              [ADDR_W-1:0] pc,
  input  logic                           pc_src,
  input  logic signed       [ADDR_W-1:0] branch_imm,
  output logic              [ADDR_W-1:0] pc_inc_2,
  output logic              [ADDR_W-1:0] pc_next
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic signed [ADDR_W-1:0] byte_offset;

  // Immediate counts instructions; the shift converts it to a byte offset.
  // All sums wrap at 16 bits with the carry discarded.
  always_comb begin
    byte_offset = branch_imm <<< 1;
    pc_inc_2    = pc + STEP;
    pc_next     = pc_src ? (pc_inc_2 + $unsigned(byte_offset)) : pc_inc_2;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: req/ack fetch from imem, valid/ready issue to decode.
// Optional macro FETCH_PERF_CNT_EN adds retired/taken-branch counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int                PC_STEP  = DEF_PC_STEP
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic        [ADDR_W-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic        [ADDR_W-1:0] imem_rdata,
  output logic        [ADDR_W-1:0] instr,
  output logic        [ADDR_W-1:0] pc_inc_2,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     PCSrc,
  input  logic signed [ADDR_W-1:0] branch_imm,
  input  logic                     hlt,
  output logic                     halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic        [31:0]       retired_cnt,
  output logic        [31:0]       taken_cnt
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next;
  logic              load_instr;
  logic              handshake;

  pc_next_calc #(
    .PC_STEP    (PC_STEP)
  ) u_pc_next (
    .pc         (pc_q),
    .pc_src     (PCSrc),
    .branch_imm (branch_imm),
    .pc_inc_2   (pc_inc_2),
    .pc_next    (pc_next)
  );

  assign imem_addr = pc_q;
  assign handshake = instr_valid && instr_ready;

  // An ack only counts against an outstanding request, so the reset cycle
  // (request still low) cannot capture stray memory data.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    load_instr = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_req && imem_ack) begin
          load_instr = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (hlt) begin
            state_d = HALTED;
          end else begin
            pc_d    = pc_next;
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if (load_instr) begin
        instr <= imem_rdata;
      end
      imem_req    <= (state_d == FETCH);
      instr_valid <= (state_d == ISSUE);
      halted      <= (state_d == HALTED);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      taken_cnt   <= '0;
    end else if (handshake) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (PCSrc && !hlt) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; producer end of the decode stage's instruction interface.
- Holds the PC and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents `instr` and `pc_inc_2` to the decoder with a valid/ready handshake.
- Applies the decoder's `PCSrc`, sign-extended immediate and `hlt` to select the next PC, or to stop.

Parameters:
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `PC_STEP`, default 2: byte increment per sequential instruction.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `imem_req`  output  1  fetch request to instruction memory.
- `imem_addr`  output  16  fetch byte address; equals the PC.
- `imem_ack`  input  1  memory returns data this cycle.
- `imem_rdata`  input  16  instruction word; valid when `imem_ack`=1.
- `instr`  output  16  latched instruction to the decoder.
- `pc_inc_2`  output  16  PC + `PC_STEP` of the issued instruction.
- `instr_valid`  output  1  `instr`/`pc_inc_2` valid.
- `instr_ready`  input  1  decoder consumes the instruction this cycle.
- `PCSrc`  input  1  branch taken; sampled only on handshake.
- `branch_imm`  input  16  sign-extended 9-bit immediate from the decoder; sampled only on handshake.
- `hlt`  input  1  halt instruction; sampled only on handshake.
- `halted`  output  1  core stopped.

Behaviour:
- States: FETCH, ISSUE, HALTED.
- Reset (`rst_n`=0 at a rising edge), from any state including mid-fetch:
  - pc=`RESET_PC`, state=FETCH, `instr`=16'h0000.
  - Registered outputs `imem_req`, `instr_valid` and `halted` = 0 for the reset cycle.
- Combinational outputs:
  - `imem_addr`=pc.
  - `pc_inc_2`=pc+`PC_STEP`, mod 2^16 (16'hFFFE+2 → 16'h0000).
- FETCH:
  - `imem_req`=1 with `imem_addr` stable until ack.
  - On `imem_ack`: `instr`←`imem_rdata`, go to ISSUE.
  - Ack is allowed in the first FETCH cycle; minimum FETCH→ISSUE latency is 1 cycle.
- ISSUE:
  - `instr_valid`=1, `imem_req`=0, `instr` held stable until `instr_ready`.
  - On `instr_valid`&`instr_ready`:
    - if `hlt`: go to HALTED, pc unchanged (points at the halt instruction).
    - else if `PCSrc`: pc←pc+`PC_STEP`+(`branch_imm`<<1), 16-bit wrap, carry discarded; go to FETCH.
    - else: pc←pc+`PC_STEP`; go to FETCH.
  - `hlt` has priority over `PCSrc`.
- HALTED: `halted`=1, `imem_req`=0, `instr_valid`=0; left only by reset.
- `imem_ack` outside FETCH is ignored; no state change.
- `PCSrc`, `branch_imm` and `hlt` are don't-care except on the handshake cycle.
- Throughput with zero-wait memory and `instr_ready` tied 1: one instruction per 2 cycles.
- No X on outputs after the first reset edge.

Optional Feature:
- Macro `FETCH_PERF_CNT_EN`.
- Defined:
  - Adds outputs `retired_cnt` [31:0] and `taken_cnt` [31:0].
  - `retired_cnt` increments on every ISSUE handshake, including the `hlt` one.
  - `taken_cnt` increments on handshakes with `PCSrc`=1 and `hlt`=0.
  - Both counters clear on reset and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum (FETCH, ISSUE, HALTED);
  - default `RESET_PC` and `PC_STEP` constants;
  - 16-bit address/instruction width constant.
- Sub-module `pc_next_calc`: combinational; inputs pc, `PCSrc`, `branch_imm`; outputs `pc_inc_2` and next-PC. Instantiated once.

Test Plan:
- Reset then zero-wait memory returning 16'hA123 at 16'h0000, `instr_ready`=1:
  - `imem_req` high cycle 1;
  - `instr`=16'hA123 and `instr_valid` on cycle 2;
  - `imem_addr`=16'h0002 on cycle 3;
  - `pc_inc_2`=16'h0002 while issuing.
- Memory ack delayed 3 cycles → `imem_addr` stable for all 4 FETCH cycles, a single ISSUE follows; an ack injected during ISSUE is ignored.
- `instr_ready`=0 for 5 cycles in ISSUE → `instr` and `instr_valid` held unchanged, pc unchanged; handshake on cycle 6 advances pc.
- PC=16'h0010, `PCSrc`=1, `branch_imm`=16'hFFFC → next fetch address 16'h000A. PC=16'hFFFE, `PCSrc`=0 → next address 16'h0000.
- `hlt`=1 and `PCSrc`=1 on the same handshake at pc 16'h0020:
  - `halted`=1, `imem_req` stays 0, pc=16'h0020;
  - `rst_n` low for one edge → FETCH at `RESET_PC`.
- With `FETCH_PERF_CNT_EN`: 4 instructions, 1 branch taken, then halt → `retired_cnt`=5, `taken_cnt`=1; reset mid-FETCH clears both counters and drops `imem_req`.
